// File: rtl/stream_pkg.sv
// Shared stream-link definitions: default widths, beat math and the IDLE/SEND encoding
// used by both the transmit serializer and the receive-side shell.
package stream_pkg;

  localparam int unsigned DefaultPayloadBits = 128;
  localparam int unsigned DefaultLinkBits    = 32;

  typedef enum logic {
    StIdle = 1'b0,
    StSend = 1'b1
  } stream_state_e;

  function automatic int unsigned num_beats(input int unsigned payload_bits,
                                            input int unsigned link_bits);
    return payload_bits / link_bits;
  endfunction

  // A single-beat link still carries a 1-bit counter so the datapath never degenerates.
  function automatic int unsigned cnt_width(input int unsigned beats);
    return (beats <= 1) ? 1 : $clog2(beats);
  endfunction

endpackage

// File: rtl/stream_tx_serializer.sv
// Splits each PAYLOAD_BITS word into LINK_BITS beats, LSB slice first, pushed to a receiver
// whose write enable is val_out; a new word may load on the last beat so the link never idles.
module stream_tx_serializer
  import stream_pkg::*;
#(
  parameter int unsigned PAYLOAD_BITS = DefaultPayloadBits,
  parameter int unsigned LINK_BITS    = DefaultLinkBits
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [PAYLOAD_BITS-1:0] din,
  input  logic                    val_in,
  output logic                    ready_upward,
  output logic [LINK_BITS-1:0]    dout,
  output logic                    val_out,
  input  logic                    ready_downward,
  output logic                    overflow
);

  localparam int unsigned NUM_BEATS = num_beats(PAYLOAD_BITS, LINK_BITS);
  localparam int unsigned CNT_BITS  = cnt_width(NUM_BEATS);
  localparam logic [CNT_BITS-1:0] LastCnt = CNT_BITS'(NUM_BEATS - 1);

  if (LINK_BITS == 0 || (PAYLOAD_BITS % LINK_BITS) != 0) begin : gen_bad_width
    $error("PAYLOAD_BITS must be a non-zero integer multiple of LINK_BITS");
  end

  stream_state_e           state_q;
  logic [CNT_BITS-1:0]     cnt_q;
  logic [PAYLOAD_BITS-1:0] shreg_q;
  logic                    overflow_q;

  logic busy;
  logic last;
  logic acc;

  always_comb begin
    busy         = (state_q == StSend);
    last         = (cnt_q == LastCnt);
    // Qualified by reset so upstream sees no permission while the block is held cleared.
    ready_upward = !reset && (!busy || (last && ready_downward));
    acc          = val_in && ready_upward;
    val_out      = !reset && busy && ready_downward;
    dout         = val_out ? shreg_q[LINK_BITS-1:0] : '0;
    overflow     = overflow_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      shreg_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (val_in && !ready_upward) begin
        overflow_q <= 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (acc) begin
            shreg_q <= din;
            cnt_q   <= '0;
            state_q <= StSend;
          end
        end
        StSend: begin
          if (ready_downward) begin
            if (!last) begin
              shreg_q <= shreg_q >> LINK_BITS;
              cnt_q   <= cnt_q + CNT_BITS'(1);
            end else if (acc) begin
              shreg_q <= din;
              cnt_q   <= '0;
            end else begin
              state_q <= StIdle;
              cnt_q   <= '0;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_tx_serializer.sv
// Scoreboard bench for stream_tx_serializer: a 4-beat link and a 1-beat link share stimulus;
// a pending-beat count model predicts handshakes and queues the expected beats.
module tb_stream_tx_serializer;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [127:0] din = '0;
  logic         val_in = 1'b0;
  logic         ready_downward = 1'b1;

  logic         ready_upward, val_out, overflow;
  logic [31:0]  dout;
  logic         ready_upward_w, val_out_w, overflow_w;
  logic [127:0] dout_w;

  stream_tx_serializer dut (
    .clk            (clk),
    .reset          (reset),
    .din            (din),
    .val_in         (val_in),
    .ready_upward   (ready_upward),
    .dout           (dout),
    .val_out        (val_out),
    .ready_downward (ready_downward),
    .overflow       (overflow)
  );

  stream_tx_serializer #(
    .PAYLOAD_BITS (128),
    .LINK_BITS    (128)
  ) dut_w (
    .clk            (clk),
    .reset          (reset),
    .din            (din),
    .val_in         (val_in),
    .ready_upward   (ready_upward_w),
    .dout           (dout_w),
    .val_out        (val_out_w),
    .ready_downward (ready_downward),
    .overflow       (overflow_w)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: unsent beats per link, sticky drop flag, and expected beat data in order.
  int           rem [2];
  bit           ovf [2];
  bit           exp_vo [2];
  bit           exp_ru [2];
  bit           exp_ovf [2];
  logic [31:0]  q0[$];
  logic [127:0] q1[$];
  bit           mon_en = 1'b0;

  localparam logic [127:0] W1 = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] W2 = 128'h88888888_77777777_66666666_55555555;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic clear_model();
    for (int k = 0; k < 2; k++) begin
      rem[k] = 0;
      ovf[k] = 1'b0;
    end
    q0.delete();
    q1.delete();
  endtask

  // One cycle of stimulus; predicts this cycle's outputs and the beats of any accepted word.
  task automatic step(input bit v, input logic [127:0] d, input bit rd);
    int nb;
    @(posedge clk);
    #1;
    val_in         = v;
    din            = d;
    ready_downward = rd;
    for (int k = 0; k < 2; k++) begin
      nb         = (k == 0) ? 4 : 1;
      exp_ovf[k] = ovf[k];
      exp_vo[k]  = (rem[k] > 0) && rd;
      exp_ru[k]  = (rem[k] == 0) || (rem[k] == 1 && rd);
      if (exp_vo[k]) rem[k]--;
      if (v) begin
        if (exp_ru[k]) begin
          rem[k] += nb;
          if (k == 0) begin
            for (int j = 0; j < 4; j++) q0.push_back(d[32*j +: 32]);
          end else begin
            q1.push_back(d);
          end
        end else begin
          ovf[k] = 1'b1;
        end
      end
    end
    mon_en = 1'b1;
  endtask

  task automatic idle(input int n, input bit rd);
    for (int i = 0; i < n; i++) step(1'b0, '0, rd);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #3;
    mon_en = 1'b0;
    reset  = 1'b1;
    #1;
    chk("rst_val_out", {127'b0, val_out}, 128'd0);
    chk("rst_dout", {96'b0, dout}, 128'd0);
    chk("rst_overflow", {127'b0, overflow}, 128'd0);
    chk("rst_ready_upward", {127'b0, ready_upward}, 128'd0);
    chk("rst_val_out_w", {127'b0, val_out_w}, 128'd0);
    chk("rst_overflow_w", {127'b0, overflow_w}, 128'd0);
    clear_model();
    @(posedge clk);
    #1;
    val_in         = 1'b0;
    ready_downward = 1'b1;
    reset          = 1'b0;
  endtask

  always @(negedge clk) begin
    if (mon_en && !reset) begin
      chk("val_out", {127'b0, val_out}, {127'b0, exp_vo[0]});
      chk("ready_upward", {127'b0, ready_upward}, {127'b0, exp_ru[0]});
      chk("overflow", {127'b0, overflow}, {127'b0, exp_ovf[0]});
      if (val_out) begin
        if (q0.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL beat_unexpected at %0t: got dout %h, expected no beat", $time, dout);
        end else begin
          chk("dout", {96'b0, dout}, {96'b0, q0.pop_front()});
        end
      end else begin
        chk("dout_idle", {96'b0, dout}, 128'd0);
      end

      chk("val_out_w", {127'b0, val_out_w}, {127'b0, exp_vo[1]});
      chk("ready_upward_w", {127'b0, ready_upward_w}, {127'b0, exp_ru[1]});
      chk("overflow_w", {127'b0, overflow_w}, {127'b0, exp_ovf[1]});
      if (val_out_w) begin
        if (q1.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL beat_unexpected_w at %0t: got dout %h, expected no beat", $time, dout_w);
        end else begin
          chk("dout_w", dout_w, q1.pop_front());
        end
      end else begin
        chk("dout_idle_w", dout_w, 128'd0);
      end
    end
  end

  initial begin
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    chk("init_val_out", {127'b0, val_out}, 128'd0);
    chk("init_dout", {96'b0, dout}, 128'd0);
    chk("init_overflow", {127'b0, overflow}, 128'd0);
    chk("init_ready_upward", {127'b0, ready_upward}, 128'd0);
    reset = 1'b0;
    idle(2, 1'b1);

    // Single word, link always ready.
    step(1'b1, W1, 1'b1);
    idle(6, 1'b1);

    // Second word pushed in the last-beat cycle: eight contiguous beats.
    step(1'b1, W1, 1'b1);
    idle(3, 1'b1);
    step(1'b1, W2, 1'b1);
    idle(6, 1'b1);

    // Receiver stalls for five cycles after beat 1.
    step(1'b1, W1, 1'b1);
    idle(2, 1'b1);
    idle(5, 1'b0);
    idle(5, 1'b1);

    // Push during beat 1 is dropped and flags overflow.
    step(1'b1, W1, 1'b1);
    step(1'b0, '0, 1'b1);
    step(1'b1, W2, 1'b1);
    idle(6, 1'b1);

    // Reset mid-word, then a fresh word from slice 0.
    step(1'b1, W2, 1'b1);
    idle(2, 1'b1);
    pulse_reset();
    idle(3, 1'b1);
    step(1'b1, W1, 1'b1);
    idle(6, 1'b1);

    // Continuous push: the 1-beat link mirrors din one cycle later.
    pulse_reset();
    for (int i = 0; i < 10; i++) step(1'b1, {$urandom, $urandom, $urandom, $urandom}, 1'b1);
    idle(6, 1'b1);

    // Random traffic with random backpressure.
    pulse_reset();
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 9) < 4, {$urandom, $urandom, $urandom, $urandom},
           $urandom_range(0, 9) < 7);
    end
    idle(10, 1'b1);

    @(posedge clk);
    #1;
    mon_en = 1'b0;
    chk("q0_drained", 128'(q0.size()), 128'd0);
    chk("q1_drained", 128'(q1.size()), 128'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
